// File: rtl/mem_responder.sv
// mem_responder: memory-side model for the five-stage pipeline.
//
// One shared word array serves three access channels:
//   - instruction fetch : pc_addr / im_command        -> instruction
//   - data port         : proc2Dmem_addr / proc2Dmem_command / proc2mem_data
//                                                     -> mem2proc_data
//   - program loader    : ld_valid / ld_ready / ld_addr / ld_data / ld_last
//
// After rst the block sits in LOAD, accepting loader beats and holding the
// processor in reset (proc_rst=1). The beat flagged ld_last moves it to RUN,
// where fetches and data accesses are served. RUN is left only through rst.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   pc_addr, im_command    fetch byte address and command (LOAD honoured only)
//   instruction            fetched word, NOOP_INST when not served
//   proc2Dmem_addr/_command, proc2mem_data   data port request and store data
//   mem2proc_data          load data, 0 unless an accepted load
//   ld_valid/ld_ready/ld_addr/ld_data/ld_last   loader stream
//   proc_rst               processor reset, high during LOAD
//   load_cnt, store_cnt    accepted data loads/stores, wrap modulo 2^32
//   err_misaligned, err_oob  sticky error flags, cleared only by rst
module mem_responder #(
  parameter int  DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic [1:0]  im_command,
  output logic [31:0] instruction,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2mem_data,
  output logic [31:0] mem2proc_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        proc_rst,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt,
  output logic        err_misaligned,
  output logic        err_oob
);

  localparam logic [1:0]  BUS_LOAD  = 2'd1;
  localparam logic [1:0]  BUS_STORE = 2'd2;
  localparam logic [31:0] NOOP_INST = 32'h0000_0013;

  // Channel numbering for the shared address checks.
  localparam int CH_IF = 0;
  localparam int CH_DM = 1;
  localparam int CH_LD = 2;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic [31:0] load_cnt_reg, load_cnt_next;
  logic [31:0] store_cnt_reg, store_cnt_next;
  logic        err_mis_reg, err_mis_next;
  logic        err_oob_reg, err_oob_next;

  // Reads are zero-latency to match the single-cycle IF/MEM stages, so the
  // array is read asynchronously (distributed RAM, not block RAM).
  logic [31:0] mem [DEPTH_WORDS];

  logic [2:0][31:0]   chan_addr;
  logic [2:0][AW-1:0] chan_idx;
  logic [2:0]         chan_mis;
  logic [2:0]         chan_oob;
  logic [2:0]         chan_act;
  logic [2:0]         chan_ok;

  logic        run;
  logic        fetch_act, dload_act, dstore_act, beat_act;
  logic        wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0] wr_data;

  assign chan_addr[CH_IF] = pc_addr;
  assign chan_addr[CH_DM] = proc2Dmem_addr;
  assign chan_addr[CH_LD] = ld_addr;

  // Alignment and range are judged independently so both flags can fire.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      assign chan_mis[gi] = (chan_addr[gi][1:0] != 2'b00);
      assign chan_oob[gi] = (chan_addr[gi][31:AW+2] != '0);
      assign chan_idx[gi] = chan_addr[gi][AW+1:2];
    end
  endgenerate

  assign run        = (state_reg == ST_RUN);
  assign fetch_act  = run && (im_command == BUS_LOAD);
  assign dload_act  = run && (proc2Dmem_command == BUS_LOAD);
  assign dstore_act = run && (proc2Dmem_command == BUS_STORE);
  assign beat_act   = !run && ld_valid;  // ld_ready is high throughout LOAD

  assign chan_act = {beat_act, dload_act | dstore_act, fetch_act};
  assign chan_ok  = chan_act & ~chan_mis & ~chan_oob;

  assign instruction   = chan_ok[CH_IF] ? mem[chan_idx[CH_IF]] : NOOP_INST;
  assign mem2proc_data = (dload_act && chan_ok[CH_DM]) ? mem[chan_idx[CH_DM]] : 32'd0;

  // Loader and store writes are mutually exclusive by state, so one write
  // port suffices. A write presented while rst is high is dropped.
  assign wr_en   = !rst && (chan_ok[CH_LD] || (dstore_act && chan_ok[CH_DM]));
  assign wr_idx  = run ? chan_idx[CH_DM] : chan_idx[CH_LD];
  assign wr_data = run ? proc2mem_data : ld_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_cnt_next  = load_cnt_reg;
    store_cnt_next = store_cnt_reg;
    err_mis_next   = err_mis_reg | (|(chan_act & chan_mis));
    err_oob_next   = err_oob_reg | (|(chan_act & chan_oob));

    if (beat_act && ld_last) begin
      state_next = ST_RUN;
    end
    if (dload_act && chan_ok[CH_DM]) begin
      load_cnt_next = load_cnt_reg + 32'd1;
    end
    if (dstore_act && chan_ok[CH_DM]) begin
      store_cnt_next = store_cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_LOAD;
      load_cnt_reg  <= 32'd0;
      store_cnt_reg <= 32'd0;
      err_mis_reg   <= 1'b0;
      err_oob_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      load_cnt_reg  <= load_cnt_next;
      store_cnt_reg <= store_cnt_next;
      err_mis_reg   <= err_mis_next;
      err_oob_reg   <= err_oob_next;
    end
  end

  assign proc_rst       = !run;
  assign ld_ready       = !run;
  assign load_cnt       = load_cnt_reg;
  assign store_cnt      = store_cnt_reg;
  assign err_misaligned = err_mis_reg;
  assign err_oob        = err_oob_reg;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: loader phase, fetch, load/store with
// same-cycle read-during-write, misaligned and out-of-range accesses,
// loader beats in RUN, and reset mid-RUN with array retention.
module tb_mem_responder;

  localparam logic [31:0] NOOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic [1:0]  im_command;
  logic [31:0] instruction;
  logic [31:0] proc2Dmem_addr;
  logic [1:0]  proc2Dmem_command;
  logic [31:0] proc2mem_data;
  logic [31:0] mem2proc_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        proc_rst;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;
  logic        err_misaligned;
  logic        err_oob;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_responder #(.DEPTH_WORDS(1024)) dut (
    .clk               (clk),
    .rst               (rst),
    .pc_addr           (pc_addr),
    .im_command        (im_command),
    .instruction       (instruction),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2mem_data     (proc2mem_data),
    .mem2proc_data     (mem2proc_data),
    .ld_valid          (ld_valid),
    .ld_ready          (ld_ready),
    .ld_addr           (ld_addr),
    .ld_data           (ld_data),
    .ld_last           (ld_last),
    .proc_rst          (proc_rst),
    .load_cnt          (load_cnt),
    .store_cnt         (store_cnt),
    .err_misaligned    (err_misaligned),
    .err_oob           (err_oob)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    im_command        = 2'd0;
    pc_addr           = 32'd0;
    proc2Dmem_command = 2'd0;
    proc2Dmem_addr    = 32'd0;
    proc2mem_data     = 32'd0;
    ld_valid          = 1'b0;
    ld_addr           = 32'd0;
    ld_data           = 32'd0;
    ld_last           = 1'b0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();

    // Reset state
    check("rst_proc_rst", {31'd0, proc_rst}, 32'd1);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("rst_load_cnt", load_cnt, 32'd0);
    check("rst_store_cnt", store_cnt, 32'd0);
    check("rst_err_mis", {31'd0, err_misaligned}, 32'd0);
    check("rst_err_oob", {31'd0, err_oob}, 32'd0);
    check("rst_instruction", instruction, NOOP);
    check("rst_mem2proc", mem2proc_data, 32'd0);

    // Program load: 0x100 seed word, then the three-instruction program
    rst = 1'b0;
    beat(32'h100, 32'h1111_1111, 1'b0); step();
    beat(32'h0, 32'h0050_0093, 1'b0);   step();
    beat(32'h4, 32'h00A0_0113, 1'b0);   step();
    beat(32'h8, 32'h0020_81B3, 1'b1);
    #1 check("load_last_proc_rst_hi", {31'd0, proc_rst}, 32'd1);
    step();
    idle();
    check("run_proc_rst", {31'd0, proc_rst}, 32'd0);
    check("run_ld_ready", {31'd0, ld_ready}, 32'd0);
    im_command = 2'd1; pc_addr = 32'h4;
    #1 check("fetch_4", instruction, 32'h00A0_0113);
    pc_addr = 32'h8;
    #1 check("fetch_8", instruction, 32'h0020_81B3);
    im_command = 2'd3;
    #1 check("fetch_cmd3_noop", instruction, NOOP);

    // c1: data load of the seed word
    idle();
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    #1 check("load_100_old", mem2proc_data, 32'h1111_1111);
    step();

    // c2: store DEADBEEF with a same-cycle fetch of the same word
    idle();
    proc2Dmem_command = 2'd2; proc2Dmem_addr = 32'h100; proc2mem_data = 32'hDEAD_BEEF;
    im_command = 2'd1; pc_addr = 32'h100;
    #1 check("rdw_fetch_old", instruction, 32'h1111_1111);
    check("store_mem2proc_zero", mem2proc_data, 32'd0);
    check("load_cnt_1", load_cnt, 32'd1);
    step();

    // c3: new word visible next cycle
    idle();
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    im_command = 2'd1; pc_addr = 32'h100;
    #1 check("load_100_new", mem2proc_data, 32'hDEAD_BEEF);
    check("fetch_100_new", instruction, 32'hDEAD_BEEF);
    check("store_cnt_1", store_cnt, 32'd1);
    step();

    // c4: misaligned store
    idle();
    check("load_cnt_2", load_cnt, 32'd2);
    proc2Dmem_command = 2'd2; proc2Dmem_addr = 32'h102; proc2mem_data = 32'h5555_5555;
    step();

    // c5: store was dropped
    idle();
    check("mis_store_flag", {31'd0, err_misaligned}, 32'd1);
    check("mis_store_cnt", store_cnt, 32'd1);
    check("mis_store_no_oob", {31'd0, err_oob}, 32'd0);
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    #1 check("mis_store_nowrite", mem2proc_data, 32'hDEAD_BEEF);
    step();

    // c6: out-of-range load and fetch
    idle();
    check("load_cnt_3", load_cnt, 32'd3);
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h1000;
    im_command = 2'd1; pc_addr = 32'h1000;
    #1 check("oob_load_zero", mem2proc_data, 32'd0);
    check("oob_fetch_noop", instruction, NOOP);
    step();

    // c7: flag visible, no count
    idle();
    check("oob_flag", {31'd0, err_oob}, 32'd1);
    check("oob_load_cnt", load_cnt, 32'd3);

    // c8: loader beat in RUN is ignored
    beat(32'h100, 32'hBAD0_BAD0, 1'b1);
    #1 check("run_beat_ld_ready", {31'd0, ld_ready}, 32'd0);
    step();
    idle();
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    #1 check("run_beat_nowrite", mem2proc_data, 32'hDEAD_BEEF);
    check("run_beat_stays_run", {31'd0, proc_rst}, 32'd0);
    step();

    // c9: reset mid-RUN with a store to 0x0 presented in the same cycle
    idle();
    rst = 1'b1;
    proc2Dmem_command = 2'd2; proc2Dmem_addr = 32'h0; proc2mem_data = 32'hFFFF_FFFF;
    step();
    rst = 1'b0;
    idle();
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    im_command = 2'd1; pc_addr = 32'h100;
    #1 check("rerst_proc_rst", {31'd0, proc_rst}, 32'd1);
    check("rerst_ld_ready", {31'd0, ld_ready}, 32'd1);
    check("rerst_load_cnt", load_cnt, 32'd0);
    check("rerst_store_cnt", store_cnt, 32'd0);
    check("rerst_err_mis", {31'd0, err_misaligned}, 32'd0);
    check("rerst_err_oob", {31'd0, err_oob}, 32'd0);
    check("load_state_instr_noop", instruction, NOOP);
    check("load_state_mem2proc_zero", mem2proc_data, 32'd0);
    step();

    // Reload skipping 0x0 and 0x100: a misaligned beat, then the last beat
    idle();
    check("load_state_no_count", load_cnt, 32'd0);
    beat(32'h106, 32'h0000_CAFE, 1'b0);
    step();
    check("ld_mis_flag", {31'd0, err_misaligned}, 32'd1);
    check("ld_mis_no_oob", {31'd0, err_oob}, 32'd0);
    check("ld_mis_still_load", {31'd0, ld_ready}, 32'd1);
    beat(32'h4, 32'h00A0_0113, 1'b1);
    step();
    idle();
    check("reload_proc_rst", {31'd0, proc_rst}, 32'd0);
    im_command = 2'd1; pc_addr = 32'h0;
    proc2Dmem_command = 2'd1; proc2Dmem_addr = 32'h100;
    #1 check("rst_store_dropped", instruction, 32'h0050_0093);
    check("retain_100", mem2proc_data, 32'hDEAD_BEEF);
    step();
    idle();
    check("reload_load_cnt", load_cnt, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
